// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported memory between an instruction-fetch requester
//   (if_*) and a data requester (dm_*). Data traffic has fixed priority.
//   Each access lasts MEM_LAT cycles. Accesses run back to back with no
//   idle cycle between them.
//
// Parameters
//   ADDR_W      address width
//   DATA_W      data width
//   MEM_LAT     cycles per memory access (1..15)
//   STARVE_MAX  data grants tolerated while fetch waits (fairness build only)
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr           fetch request
//   if_gnt/if_valid/if_rdata fetch grant, completion pulse, fetched word
//   dm_req/dm_we/dm_addr/dm_wdata/dm_size/dm_signed   data request
//   dm_gnt/dm_valid/dm_rdata data grant, completion pulse, load data
//   mem_read/mem_write       memory strobes, held for the whole access
//   mem_addr/mem_wdata/mem_size/mem_signed   latched request to memory
//   mem_rdata                memory read data
//   stall_if                 fetch stall to the pipeline (if_req & ~if_valid)
//
// Build option
//   MEM_ARB_FAIRNESS_EN  when defined, fetch wins once STARVE_MAX data grants
//                        have been made in a row while fetch was waiting.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [1:0]        dm_size,
  input  logic              dm_signed,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  output logic              mem_signed,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if
);

  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC} state_t;

  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

  // Fetch has no size or sign field of its own; it always reads a full word.
  localparam logic [1:0] FETCH_SIZE = 2'b10;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              arb_edge;
  logic              last_cyc;
  logic              fetch_force;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              signed_q;

  // A new winner is picked whenever the port is free or finishing its last cycle.
  assign arb_edge = (state == IDLE) || (cnt == LAST);
  assign last_cyc = (state != IDLE) && (cnt == LAST);

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve;

  assign fetch_force = (starve == SW'(STARVE_MAX));

  // Counts data grants made over a waiting fetch. It cannot pass STARVE_MAX,
  // because at that value a waiting fetch takes the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (arb_edge) begin
      if (state_nxt == IF_ACC)                starve <= '0;
      else if (state_nxt == DM_ACC && if_req) starve <= starve + SW'(1);
    end
  end
`else
  assign fetch_force = 1'b0;
`endif

  // NOTE: every variable gets a default at the top of a combinational block so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (arb_edge) begin
      if (dm_req && !(if_req && fetch_force)) state_nxt = DM_ACC;
      else if (if_req)                        state_nxt = IF_ACC;
      else                                    state_nxt = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the request and data registers are plain flops, not a RAM array, so all of them reset to a known zero.
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (arb_edge) begin
        cnt <= '0;
        case (state_nxt)
          DM_ACC: begin
            addr_q   <= dm_addr;
            wdata_q  <= dm_wdata;
            we_q     <= dm_we;
            size_q   <= dm_size;
            signed_q <= dm_signed;
          end
          IF_ACC: begin
            addr_q   <= if_addr;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            size_q   <= FETCH_SIZE;
            signed_q <= 1'b0;
          end
          default: ;
        endcase
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  // The last access cycle completes at its closing edge. A store leaves dm_rdata unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_valid <= last_cyc && (state == IF_ACC);
      dm_valid <= last_cyc && (state == DM_ACC);
      if (last_cyc && state == IF_ACC)          if_rdata <= mem_rdata;
      if (last_cyc && state == DM_ACC && !we_q) dm_rdata <= mem_rdata;
    end
  end

  // Grants mark the first cycle of an access. cnt is 0 only in that cycle,
  // except when MEM_LAT = 1, where every cycle is a first cycle.
  assign if_gnt     = (state == IF_ACC) && (cnt == 4'd0);
  assign dm_gnt     = (state == DM_ACC) && (cnt == 4'd0);

  assign mem_read   = (state == IF_ACC) || (state == DM_ACC && !we_q);
  assign mem_write  = (state == DM_ACC) && we_q;
  assign mem_addr   = (state != IDLE) ? addr_q   : '0;
  assign mem_wdata  = (state != IDLE) ? wdata_q  : '0;
  assign mem_size   = (state != IDLE) ? size_q   : '0;
  assign mem_signed = (state != IDLE) ? signed_q : 1'b0;

  assign stall_if   = if_req && !if_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Three arbiter lanes with MEM_LAT = 1, 2, 3. Each lane has its own inputs.
//   Clock and reset are shared. A transaction-level model per lane predicts
//   every output. Outputs are compared on each falling edge, and directed
//   scenarios add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int NL    = 3;
  localparam int STARV = 4;

  typedef enum {K_NONE, K_IF, K_DM} kind_t;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        if_req_a    [NL];
  logic [7:0]  if_addr_a   [NL];
  logic        dm_req_a    [NL];
  logic        dm_we_a     [NL];
  logic [7:0]  dm_addr_a   [NL];
  logic [31:0] dm_wdata_a  [NL];
  logic [1:0]  dm_size_a   [NL];
  logic        dm_signed_a [NL];
  logic [31:0] mem_rdata_a [NL];

  logic        if_gnt_a     [NL];
  logic        if_valid_a   [NL];
  logic [31:0] if_rdata_a   [NL];
  logic        dm_gnt_a     [NL];
  logic        dm_valid_a   [NL];
  logic [31:0] dm_rdata_a   [NL];
  logic        mem_read_a   [NL];
  logic        mem_write_a  [NL];
  logic [7:0]  mem_addr_a   [NL];
  logic [31:0] mem_wdata_a  [NL];
  logic [1:0]  mem_size_a   [NL];
  logic        mem_signed_a [NL];
  logic        stall_if_a   [NL];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int LAT = g + 1;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(STARV)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req_a[g]), .if_addr(if_addr_a[g]),
      .if_gnt(if_gnt_a[g]), .if_valid(if_valid_a[g]), .if_rdata(if_rdata_a[g]),
      .dm_req(dm_req_a[g]), .dm_we(dm_we_a[g]), .dm_addr(dm_addr_a[g]),
      .dm_wdata(dm_wdata_a[g]), .dm_size(dm_size_a[g]), .dm_signed(dm_signed_a[g]),
      .dm_gnt(dm_gnt_a[g]), .dm_valid(dm_valid_a[g]), .dm_rdata(dm_rdata_a[g]),
      .mem_read(mem_read_a[g]), .mem_write(mem_write_a[g]), .mem_addr(mem_addr_a[g]),
      .mem_wdata(mem_wdata_a[g]), .mem_size(mem_size_a[g]), .mem_signed(mem_signed_a[g]),
      .mem_rdata(mem_rdata_a[g]), .stall_if(stall_if_a[g])
    );

    // Model: the access in flight (kind, age in cycles since grant, request
    // fields) and the completion results.
    kind_t       kind;
    int          age;
    int          starve;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata, m_ifr, m_dmr;
    logic        m_we, m_sgn, m_ifv, m_dmv;
    logic [1:0]  m_size;
    bit          fetch_wins;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        kind = K_NONE; age = 0; starve = 0;
        m_addr = '0; m_wdata = '0; m_we = 0; m_size = '0; m_sgn = 0;
        m_ifv = 0; m_dmv = 0; m_ifr = '0; m_dmr = '0;
      end else begin
        m_ifv = 0;
        m_dmv = 0;
        if (kind != K_NONE) begin
          age++;
          if (age == LAT) begin
            if (kind == K_IF) begin
              m_ifv = 1; m_ifr = mem_rdata_a[g];
            end else begin
              m_dmv = 1;
              if (!m_we) m_dmr = mem_rdata_a[g];
            end
            kind = K_NONE;
          end
        end
        if (kind == K_NONE) begin
          fetch_wins = if_req_a[g] && !dm_req_a[g];
`ifdef MEM_ARB_FAIRNESS_EN
          if (if_req_a[g] && starve == STARV) fetch_wins = 1;
`endif
          age = 0;
          if (dm_req_a[g] && !fetch_wins) begin
            kind = K_DM;
            m_addr = dm_addr_a[g]; m_wdata = dm_wdata_a[g]; m_we = dm_we_a[g];
            m_size = dm_size_a[g]; m_sgn = dm_signed_a[g];
            if (if_req_a[g]) starve++;
          end else if (if_req_a[g]) begin
            kind = K_IF;
            m_addr = if_addr_a[g]; m_wdata = '0; m_we = 0; m_size = 2'b10; m_sgn = 0;
            starve = 0;
          end
        end
      end
    end

    always @(negedge clk) begin
      logic busy;
      busy = (kind != K_NONE);
      check($sformatf("L%0d ctl{ig,dg,iv,dv,rd,wr,st}", g),
            {if_gnt_a[g], dm_gnt_a[g], if_valid_a[g], dm_valid_a[g],
             mem_read_a[g], mem_write_a[g], stall_if_a[g]},
            {(kind == K_IF && age == 0), (kind == K_DM && age == 0), m_ifv, m_dmv,
             (kind == K_IF) || (kind == K_DM && !m_we), (kind == K_DM && m_we),
             if_req_a[g] && !m_ifv});
      check($sformatf("L%0d mem_addr", g),  mem_addr_a[g],  busy ? m_addr  : 8'h0);
      check($sformatf("L%0d mem_wdata", g), mem_wdata_a[g], busy ? m_wdata : 32'h0);
      check($sformatf("L%0d mem_size/sgn", g), {mem_size_a[g], mem_signed_a[g]},
            busy ? {m_size, m_sgn} : 3'b0);
      check($sformatf("L%0d if_rdata", g), if_rdata_a[g], m_ifr);
      check($sformatf("L%0d dm_rdata", g), dm_rdata_a[g], m_dmr);
    end
  end

  // Inputs change 2 time units after each rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int n_if, n_dm;
    for (int l = 0; l < NL; l++) begin
      if_req_a[l] = 0; if_addr_a[l] = '0; dm_req_a[l] = 0; dm_we_a[l] = 0;
      dm_addr_a[l] = '0; dm_wdata_a[l] = '0; dm_size_a[l] = '0; dm_signed_a[l] = 0;
      mem_rdata_a[l] = '0;
    end
    step(2);
    check("reset mem_read", mem_read_a[0], 1'b0);
    check("reset if_rdata", if_rdata_a[2], 32'h0);
    rst = 0;

    // MEM_LAT=1 single fetch
    if_req_a[0] = 1; if_addr_a[0] = 8'h04; mem_rdata_a[0] = 32'h00500093;
    step();
    check("f1 if_gnt", if_gnt_a[0], 1'b1);
    check("f1 mem_read", mem_read_a[0], 1'b1);
    check("f1 mem_addr", mem_addr_a[0], 8'h04);
    check("f1 stall_if", stall_if_a[0], 1'b1);
    if_req_a[0] = 0;
    step();
    check("f1 if_valid", if_valid_a[0], 1'b1);
    check("f1 if_rdata", if_rdata_a[0], 32'h00500093);
    check("f1 idle mem_read", mem_read_a[0], 1'b0);
    step(2);

    // MEM_LAT=3: store and fetch collide, store first
    if_req_a[2] = 1; if_addr_a[2] = 8'h08;
    dm_req_a[2] = 1; dm_we_a[2] = 1; dm_addr_a[2] = 8'h40; dm_wdata_a[2] = 32'hDEADBEEF;
    dm_size_a[2] = 2'b10;
    step();
    check("c1 dm_gnt", dm_gnt_a[2], 1'b1);
    check("c1 if_gnt", if_gnt_a[2], 1'b0);
    check("c1 mem_write", mem_write_a[2], 1'b1);
    check("c1 mem_addr", mem_addr_a[2], 8'h40);
    check("c1 mem_wdata", mem_wdata_a[2], 32'hDEADBEEF);
    dm_req_a[2] = 0; dm_we_a[2] = 0; dm_wdata_a[2] = '0;
    step();
    check("c2 mem_write", mem_write_a[2], 1'b1);
    step();
    check("c3 mem_write", mem_write_a[2], 1'b1);
    mem_rdata_a[2] = 32'h12345678;
    step();
    check("c4 dm_valid", dm_valid_a[2], 1'b1);
    check("c4 if_gnt", if_gnt_a[2], 1'b1);
    check("c4 mem_write", mem_write_a[2], 1'b0);
    check("c4 mem_addr", mem_addr_a[2], 8'h08);
    check("c4 stall_if", stall_if_a[2], 1'b1);
    check("c4 dm_rdata kept", dm_rdata_a[2], 32'h0);
    step(2);
    check("c6 stall_if", stall_if_a[2], 1'b1);
    step();
    check("c7 if_valid", if_valid_a[2], 1'b1);
    check("c7 if_rdata", if_rdata_a[2], 32'h12345678);
    check("c7 stall_if", stall_if_a[2], 1'b0);
    if_req_a[2] = 0;
    step(4);

    // MEM_LAT=2: IF, DM load, IF with no idle cycle
    if_req_a[1] = 1; if_addr_a[1] = 8'h20; mem_rdata_a[1] = 32'hAAAA0001;
    step();
    check("s1 if_gnt", if_gnt_a[1], 1'b1);
    dm_req_a[1] = 1; dm_we_a[1] = 0; dm_addr_a[1] = 8'h10; dm_size_a[1] = 2'b01; dm_signed_a[1] = 1;
    step();
    check("s2 mem_read", mem_read_a[1], 1'b1);
    step();
    check("s3 dm_gnt", dm_gnt_a[1], 1'b1);
    check("s3 if_valid", if_valid_a[1], 1'b1);
    check("s3 if_rdata", if_rdata_a[1], 32'hAAAA0001);
    check("s3 mem_addr", mem_addr_a[1], 8'h10);
    check("s3 size/sgn", {mem_size_a[1], mem_signed_a[1]}, 3'b011);
    dm_req_a[1] = 0; dm_signed_a[1] = 0; dm_size_a[1] = 0; mem_rdata_a[1] = 32'hCAFE0011;
    step();
    check("s4 mem_read", mem_read_a[1], 1'b1);
    step();
    check("s5 if_gnt", if_gnt_a[1], 1'b1);
    check("s5 dm_valid", dm_valid_a[1], 1'b1);
    check("s5 dm_rdata", dm_rdata_a[1], 32'hCAFE0011);
    check("s5 mem_addr", mem_addr_a[1], 8'h20);
    if_req_a[1] = 0;
    step(3);

    // MEM_LAT=3: reset aborts a store in flight
    dm_req_a[2] = 1; dm_we_a[2] = 1; dm_addr_a[2] = 8'h44; dm_wdata_a[2] = 32'h55;
    if_req_a[2] = 1; if_addr_a[2] = 8'h0C;
    step();
    check("r1 dm_gnt", dm_gnt_a[2], 1'b1);
    dm_req_a[2] = 0; dm_we_a[2] = 0;
    step();
    check("r2 mem_write", mem_write_a[2], 1'b1);
    #1 rst = 1;
    #1;
    check("r2 async mem_write", mem_write_a[2], 1'b0);
    check("r2 async mem_addr", mem_addr_a[2], 8'h00);
    check("r2 async stall_if", stall_if_a[2], 1'b1);
    step();
    check("r3 dm_valid", dm_valid_a[2], 1'b0);
    rst = 0;
    step();
    check("r4 if_gnt", if_gnt_a[2], 1'b1);
    check("r4 mem_addr", mem_addr_a[2], 8'h0C);
    check("r4 dm_valid", dm_valid_a[2], 1'b0);
    if_req_a[2] = 0;
    step(4);

    // MEM_LAT=1: both requests held for 10 cycles
    if_req_a[0] = 1; if_addr_a[0] = 8'h00; dm_req_a[0] = 1; dm_addr_a[0] = 8'h30;
    n_if = 0; n_dm = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_if += int'(if_gnt_a[0]);
      n_dm += int'(dm_gnt_a[0]);
    end
`ifdef MEM_ARB_FAIRNESS_EN
    check("fair dm grants", n_dm, 8);
    check("fair if grants", n_if, 2);
`else
    check("strict dm grants", n_dm, 10);
    check("strict if grants", n_if, 0);
`endif
    if_req_a[0] = 0; dm_req_a[0] = 0;
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: memory address width.
REQ-002 Parameter DATA_W, default 32: data width.
REQ-003 Parameter MEM_LAT, default 1: cycles per memory access; legal range 1..15.
REQ-004 Parameter STARVE_MAX, default 4: consecutive data grants allowed while fetch waits (used only under REQ-027).
REQ-005 Timing: one clock; reset is asynchronous and active-high.
REQ-006 Ports, in order:
- clk  in  1  system clock
- rst  in  1  async active-high reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch granted
- if_valid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetched instruction
- dm_req  in  1  data request
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_size  in  2  access size code
- dm_signed  in  1  signed load
- dm_gnt  out  1  data granted
- dm_valid  out  1  data done
- dm_rdata  out  DATA_W  load data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_size  out  2  size to memory
- mem_signed  out  1  sign to memory
- mem_rdata  in  DATA_W  memory read data
- stall_if  out  1  fetch stall to pipeline

Function
REQ-007 FSM states: IDLE, IF_ACC, DM_ACC; latency counter cnt counts 0..MEM_LAT-1.
REQ-008 Arbitration edges: any edge in IDLE, or any edge in IF_ACC/DM_ACC with cnt == MEM_LAT-1.
REQ-009 At an arbitration edge: dm_req=1 -> DM_ACC; else if_req=1 -> IF_ACC; else -> IDLE.
- Fixed data priority (MEM-stage traffic wins).
- Back-to-back accesses carry no idle bubble.
REQ-010 On entering an access state:
- Latch the winner's address, wdata, we, size and signed.
- Clear cnt to 0.
- Assert the matching gnt (if_gnt or dm_gnt) for exactly that first access cycle.
REQ-011 Requesters hold req and request fields stable until gnt; fields may change after gnt without affecting the access in flight.
REQ-012 During an access, mem_addr, mem_wdata, mem_size and mem_signed come from the latched request.
- mem_read = 1 for IF_ACC, or DM_ACC with we=0.
- mem_write = 1 for DM_ACC with we=1.
- Strobes are held for all MEM_LAT cycles.
REQ-013 In IDLE: mem_read = mem_write = 0; mem_addr, mem_wdata, mem_size and mem_signed = 0.
REQ-014 Completion at the edge ending the last access cycle (cnt == MEM_LAT-1):
- IF_ACC: register mem_rdata into if_rdata; assert if_valid for one cycle.
- DM load: register mem_rdata into dm_rdata; assert dm_valid for one cycle.
- DM store: assert dm_valid for one cycle; dm_rdata unchanged.
REQ-015 if_rdata and dm_rdata hold their last value until the next completion of the same type.
REQ-016 Latency: grant cycle to valid cycle is MEM_LAT cycles; if_req sample to if_valid is MEM_LAT+1 cycles when the port is free.
REQ-017 stall_if = if_req AND NOT if_valid (combinational).
REQ-018 if_req and dm_req both asserted at the same edge: data granted; fetch waits; stall_if stays 1.
REQ-019 A request raised during an access is not granted before that access's last cycle.
REQ-020 Address fields are passed through unmodified; no wrap or range checking in this block.

Reset
REQ-021 rst=1 forces immediately, independent of clk:
- state = IDLE, cnt = 0.
- All gnt/valid outputs = 0; mem_read = mem_write = 0.
- if_rdata = dm_rdata = 0; all latched request fields = 0.
- starvation counter = 0.
REQ-022 Reset during an access aborts it: no valid pulse is produced for that access, and a store in flight may be incomplete.
REQ-023 The first arbitration edge is the first rising clk edge with rst=0.
REQ-024 stall_if follows REQ-017 during reset.

Configuration
REQ-025 Macro MEM_ARB_FAIRNESS_EN selects anti-starvation.
REQ-026 Without the macro: strict data priority; fetch may wait indefinitely; STARVE_MAX is ignored.
REQ-027 With the macro, a starvation counter (width clog2(STARVE_MAX+1)) operates as follows:
- Increments on each data grant made while if_req=1.
- Clears on each fetch grant.
- When it equals STARVE_MAX and both requests are present, fetch wins the arbitration edge.

Verification
REQ-028 MEM_LAT=1, if_req=1, if_addr=8'h04, mem_rdata=32'h00500093 -> if_gnt at cycle 1, mem_read=1 with mem_addr=8'h04 at cycle 1, if_valid=1 with if_rdata=32'h00500093 at cycle 2.
REQ-029 MEM_LAT=3, both requests at the same edge; dm_we=1, dm_addr=8'h40, dm_wdata=32'hDEADBEEF -> dm_gnt first; mem_write=1 for 3 cycles; dm_valid pulses; if_gnt on the next cycle with no bubble; stall_if=1 until if_valid.
REQ-030 MEM_LAT=2, continuous if_req with a dm load to 8'h10 -> grant sequence IF, DM, IF; dm_rdata = mem_rdata sampled at the end of the DM access; no IDLE cycle between accesses.
REQ-031 rst asserted in the second cycle of a MEM_LAT=3 store -> mem_write drops at once; no dm_valid; after release the first edge grants any pending request.
REQ-032 With MEM_ARB_FAIRNESS_EN, STARVE_MAX=4, both requests held high -> four dm_gnt, then one if_gnt, repeating; without the macro -> dm_gnt only and if_gnt never asserts.
